// File: rtl/status_sched_pkg.sv
// Shared types, widths and helper functions for the status event scheduler.
package status_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam int STS_W  = 8;
    localparam int DROP_W = 8;
    localparam int WDOG_W = 16;

    // Number of set bits in an event vector (0..8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Mask with the low n bits set; used to drop unimplemented event sources.
    function automatic logic [7:0] low_mask(input int n);
        logic [7:0] m;
        m = 8'd0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/status_event_scheduler_if.sv
// Event/status bus between the event sources, CPU handshake and the scheduler.
// master: the side driving events and acks; slave: the scheduler itself.
interface status_event_scheduler_if;
    import status_sched_pkg::*;

    logic [STS_W-1:0]  event_in;
    logic              rd_ack;
    logic              drop_clr;
    logic [STS_W-1:0]  status_out;
    logic              intr;
    logic              busy;
    logic [DROP_W-1:0] drop_count;
    logic              timeout;

    modport master (
        output event_in, rd_ack, drop_clr,
        input  status_out, intr, busy, drop_count, timeout
    );

    modport slave (
        input  event_in, rd_ack, drop_clr,
        output status_out, intr, busy, drop_count, timeout
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: adds inc each cycle, sticks at all-ones, clr wins.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W:0]   sum_s;
    logic [W-1:0] count_r;

    // Widened sum so the carry out flags saturation.
    always_comb begin
        sum_s = {1'b0, count_r} + {1'b0, inc};
    end

    // Count register: clear has priority, then saturate on overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (sum_s[W]) begin
            count_r <= '1;
        end else begin
            count_r <= sum_s[W-1:0];
        end
    end

    assign count = count_r;

endmodule

// File: rtl/status_event_scheduler.sv
// Status event scheduler: gathers event pulses into sticky pending bits and
// hands them to the CPU as atomic snapshots with an interrupt and ack handshake.
// Optional feature macro: STATUS_SCHED_TIMEOUT_EN (ack watchdog with auto-release).
module status_event_scheduler
    import status_sched_pkg::*;
#(
    parameter int             NumInputs     = 8,
    parameter logic [STS_W-1:0] IntMask     = 8'hFF,
    parameter int             TimeoutCycles = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    status_event_scheduler_if.slave  bus
);

    localparam logic [STS_W-1:0] IN_MASK  = low_mask(NumInputs);
    localparam logic [STS_W-1:0] IRQ_MASK = IntMask & IN_MASK;

    state_e             state_r;
    logic [STS_W-1:0]   pending_r;
    logic [STS_W-1:0]   snapshot_r;
    logic [STS_W-1:0]   status_out_r;
    logic               intr_r;
    logic               busy_r;
    logic [STS_W-1:0]   event_s;
    logic [DROP_W-1:0]  drop_inc_s;
    logic [DROP_W-1:0]  drop_count_s;
    logic               expire_s;
    logic               timeout_s;

    // Qualify events by implemented sources and count repeats of pending bits.
    always_comb begin
        event_s    = bus.event_in & IN_MASK;
        drop_inc_s = {4'd0, popcount8(event_s & pending_r)};
    end

    sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (drop_inc_s),
        .clr   (bus.drop_clr),
        .count (drop_count_s)
    );

`ifdef STATUS_SCHED_TIMEOUT_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TimeoutCycles - 1);

    logic [WDOG_W-1:0] wdog_s;
    logic [WDOG_W-1:0] wdog_inc_s;
    logic              wdog_clr_s;
    logic              timeout_r;

    // Watchdog only advances while a snapshot is outstanding; held at 0 otherwise.
    always_comb begin
        wdog_inc_s = {{(WDOG_W-1){1'b0}}, (state_r == PRESENT)};
        wdog_clr_s = (state_r != PRESENT);
        expire_s   = (state_r == PRESENT) && !bus.rd_ack && (wdog_s == WDOG_LAST);
    end

    sat_counter #(.W(WDOG_W)) u_wdog_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (wdog_inc_s),
        .clr   (wdog_clr_s),
        .count (wdog_s)
    );

    // Sticky timeout flag: set by watchdog release, cleared by a real ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_r <= 1'b0;
        end else if ((state_r == PRESENT) && bus.rd_ack) begin
            timeout_r <= 1'b0;
        end else if (expire_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign timeout_s = timeout_r;
`else
    assign expire_s  = 1'b0;
    assign timeout_s = 1'b0;
`endif

    // Snapshot FSM with pending accumulation and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            pending_r    <= '0;
            snapshot_r   <= '0;
            status_out_r <= '0;
            intr_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pending_r != '0) begin
                        snapshot_r   <= pending_r;
                        pending_r    <= event_s;
                        status_out_r <= pending_r;
                        intr_r       <= |(pending_r & IRQ_MASK);
                        busy_r       <= 1'b1;
                        state_r      <= PRESENT;
                    end else begin
                        pending_r    <= pending_r | event_s;
                        status_out_r <= '0;
                        intr_r       <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                PRESENT: begin
                    pending_r <= pending_r | event_s;
                    if (bus.rd_ack || expire_s) begin
                        snapshot_r   <= '0;
                        status_out_r <= '0;
                        intr_r       <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= HOLDOFF;
                    end else begin
                        state_r      <= PRESENT;
                    end
                end
                HOLDOFF: begin
                    // One cycle with intr low so back-to-back snapshots are distinguishable.
                    pending_r    <= pending_r | event_s;
                    status_out_r <= '0;
                    intr_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    pending_r    <= '0;
                    snapshot_r   <= '0;
                    status_out_r <= '0;
                    intr_r       <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.status_out = status_out_r;
    assign bus.intr       = intr_r;
    assign bus.busy       = busy_r;
    assign bus.drop_count = drop_count_s;
    assign bus.timeout    = timeout_s;

endmodule
